// File: rtl/sysid_check_pkg.sv
// -----------------------------------------------------------------------------
// sysid_check_pkg
// Shared definitions for the system-ID check sequencer:
//   - state_e          : sequencer FSM states
//   - ADDR_ID/ADDR_TS  : word selects on the system-ID slave
//   - DEF_TIMEOUT_CYC  : default per-read waitrequest budget
//   - timer_width()    : counter width needed to reach a given cycle limit
// -----------------------------------------------------------------------------
package sysid_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_ID = 2'd1,
    ST_RD_TS = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam int unsigned DEF_TIMEOUT_CYC = 32'd256;

  // Bits needed to count 0 .. n-1 (never less than one bit).
  function automatic int unsigned timer_width(input int unsigned n);
    int unsigned w;
    if (n <= 32'd2) begin
      w = 32'd1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/sysid_check_if.sv
// -----------------------------------------------------------------------------
// sysid_check_if
// Avalon-MM read-only link between the check sequencer and the system-ID slave.
//   avm_address     : word select (0 = system ID, 1 = build timestamp)
//   avm_read        : read strobe
//   avm_readdata    : read data, valid in the cycle waitrequest is low
//   avm_waitrequest : slave stall
// Modports: master (sequencer side), slave (system-ID side).
// -----------------------------------------------------------------------------
interface sysid_check_if;

  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata,
    output avm_waitrequest
  );

endinterface

// File: rtl/sysid_check_timer.sv
// -----------------------------------------------------------------------------
// sysid_check_timer
// Small up-counter with clear, enable and terminal-count flag.
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset (count -> 0)
//   clr_i   : clear count to 0 (wins over en_i)
//   en_i    : advance count by one; count holds once terminal is reached
//   tc_o    : count has reached LIMIT-1
// Used as the per-read waitrequest timeout and, when enabled, as the
// periodic re-check trigger (clr_i tied to tc_o to make it wrap).
// -----------------------------------------------------------------------------
module sysid_check_timer
  import sysid_check_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned    W    = timer_width(LIMIT);
  localparam logic [W-1:0]   LAST = W'(LIMIT - 32'd1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign tc_o = (count_q == LAST);

  // Next count: clear, advance until terminal, or hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {W{1'b0}};
    end else if (en_i && !tc_o) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sysid_check_ctrl.sv
// -----------------------------------------------------------------------------
// sysid_check_ctrl
// Avalon-MM master sequencer that reads the system-ID slave (word 0 = ID,
// word 1 = build timestamp), compares both words with EXP_ID / EXP_TS and
// reports the result. Each read is bounded by a waitrequest timeout.
//
// Ports:
//   clk, reset_n      : clock, synchronous active-low reset
//   start             : one-cycle check request (ignored unless idle)
//   busy              : check in progress (cycle after accept .. done)
//   done              : one-cycle pulse at end of check (pass, fail or abort)
//   id_ok, ts_ok      : last captured word matched its expected value
//   timeout_err       : last check aborted on waitrequest timeout
//   id_value,ts_value : last captured words
//   mismatch_sticky   : (periodic build only) any check ever failed
//   avm               : Avalon-MM master modport (sysid_check_if)
//
// Optional build macro SYSID_CHECK_PERIODIC_EN adds a free-running trigger
// that starts a check every PERIOD_CYC cycles, a pending flag for triggers
// that arrive while busy, and the mismatch_sticky output.
// -----------------------------------------------------------------------------
module sysid_check_ctrl
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXP_ID      = 32'h0000_0000,
  parameter logic [31:0] EXP_TS      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
`ifdef SYSID_CHECK_PERIODIC_EN
  ,
  parameter int unsigned PERIOD_CYC  = 32'd1_000_000
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 id_ok,
  output logic                 ts_ok,
  output logic                 timeout_err,
  output logic [31:0]          id_value,
  output logic [31:0]          ts_value,
`ifdef SYSID_CHECK_PERIODIC_EN
  output logic                 mismatch_sticky,
`endif
  sysid_check_if.master        avm
);

  state_e state_q, state_d;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic read_q, read_d;
  logic addr_q, addr_d;

  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_err_q, timeout_err_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;

  logic        go_s;
  logic        in_rd_s;
  logic        wait_s;
  logic [31:0] rdata_s;
  logic        tmo_clr_s;
  logic        tmo_tc_s;

  assign wait_s  = avm.avm_waitrequest;
  assign rdata_s = avm.avm_readdata;
  assign in_rd_s = (state_q == ST_RD_ID) || (state_q == ST_RD_TS);

  // ---------------------------------------------------------------------------
  // Start qualification (periodic trigger and pending request when enabled)
  // ---------------------------------------------------------------------------
`ifdef SYSID_CHECK_PERIODIC_EN
  logic trig_s;
  logic pending_q, pending_d;
  logic sticky_q, sticky_d;

  sysid_check_timer #(
    .LIMIT (PERIOD_CYC)
  ) u_period (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (trig_s),
    .en_i    (1'b1),
    .tc_o    (trig_s)
  );

  assign go_s = (state_q == ST_IDLE) && (start || trig_s || pending_q);

  // Trigger that lands while a check runs is remembered; any accept clears it.
  always_comb begin
    pending_d = pending_q;
    if (state_q == ST_IDLE) begin
      pending_d = 1'b0;
    end else if (trig_s) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  // Sticky failure flag, evaluated on the finished check's result.
  always_comb begin
    sticky_d = sticky_q;
    if (state_q == ST_FIN) begin
      sticky_d = sticky_q | ~id_ok_q | ~ts_ok_q | timeout_err_q;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Pending and sticky registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_q <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      sticky_q  <= sticky_d;
    end
  end

  assign mismatch_sticky = sticky_q;
`else
  assign go_s = (state_q == ST_IDLE) && start;
`endif

  // ---------------------------------------------------------------------------
  // Per-read waitrequest timeout: cleared outside reads and on every state
  // change, so each read state starts from zero.
  // ---------------------------------------------------------------------------
  assign tmo_clr_s = !in_rd_s || (state_d != state_q);

  sysid_check_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (tmo_clr_s),
    .en_i    (in_rd_s && wait_s),
    .tc_o    (tmo_tc_s)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. A read completing in the terminal timer cycle still completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (go_s) begin
          state_d = ST_RD_ID;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_ID: begin
        if (!wait_s) begin
          state_d = ST_RD_TS;
        end else if (tmo_tc_s) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_RD_ID;
        end
      end
      ST_RD_TS: begin
        if (!wait_s || tmo_tc_s) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_RD_TS;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the next state, so the registered copies
  // line up exactly with the state register.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    read_d = 1'b0;
    addr_d = ADDR_ID;
    case (state_d)
      ST_IDLE: begin
        busy_d = 1'b0;
      end
      ST_RD_ID: begin
        busy_d = 1'b1;
        read_d = 1'b1;
        addr_d = ADDR_ID;
      end
      ST_RD_TS: begin
        busy_d = 1'b1;
        read_d = 1'b1;
        addr_d = ADDR_TS;
      end
      ST_FIN: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      read_q <= 1'b0;
      addr_q <= ADDR_ID;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      read_q <= read_d;
      addr_q <= addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Result datapath
  // ---------------------------------------------------------------------------
  // Capture on zero-latency completion; a timeout invalidates both results
  // but leaves any already captured word in place.
  always_comb begin
    id_ok_d       = id_ok_q;
    ts_ok_d       = ts_ok_q;
    timeout_err_d = timeout_err_q;
    id_value_d    = id_value_q;
    ts_value_d    = ts_value_q;
    case (state_q)
      ST_IDLE: begin
        if (go_s) begin
          timeout_err_d = 1'b0;
        end else begin
          timeout_err_d = timeout_err_q;
        end
      end
      ST_RD_ID: begin
        if (!wait_s) begin
          id_value_d = rdata_s;
          id_ok_d    = (rdata_s == EXP_ID);
        end else if (tmo_tc_s) begin
          timeout_err_d = 1'b1;
          id_ok_d       = 1'b0;
          ts_ok_d       = 1'b0;
        end else begin
          id_value_d = id_value_q;
        end
      end
      ST_RD_TS: begin
        if (!wait_s) begin
          ts_value_d = rdata_s;
          ts_ok_d    = (rdata_s == EXP_TS);
        end else if (tmo_tc_s) begin
          timeout_err_d = 1'b1;
          id_ok_d       = 1'b0;
          ts_ok_d       = 1'b0;
        end else begin
          ts_value_d = ts_value_q;
        end
      end
      ST_FIN: begin
        id_value_d = id_value_q;
      end
      default: begin
        id_value_d = id_value_q;
      end
    endcase
  end

  // Result registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      id_value_q    <= 32'h0000_0000;
      ts_value_q    <= 32'h0000_0000;
    end else begin
      id_ok_q       <= id_ok_d;
      ts_ok_q       <= ts_ok_d;
      timeout_err_q <= timeout_err_d;
      id_value_q    <= id_value_d;
      ts_value_q    <= ts_value_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign id_ok           = id_ok_q;
  assign ts_ok           = ts_ok_q;
  assign timeout_err     = timeout_err_q;
  assign id_value        = id_value_q;
  assign ts_value        = ts_value_q;
  assign avm.avm_read    = read_q;
  assign avm.avm_address = addr_q;

endmodule

// File: doc/sysid_check_ctrl.md
Name: sysid_check_ctrl

Overview:
- Avalon-MM master sequencer that reads the two-word system-ID slave: address 0 holds the system ID, address 1 holds the build timestamp.
- Compares both words against expected parameter values and reports pass/fail to the host/status block.
- Sits between the boot/status logic and the system-ID control slave.
- Provides a bounded-time handshake with a waitrequest timeout.

Parameters:
- EXP_ID, 32'h0000_0000, expected system ID word (address 0).
- EXP_TS, 32'h0000_0000, expected timestamp word (address 1).
- TIMEOUT_CYC, 256, max cycles a single read may stall on waitrequest; range 2..65535.
- PERIOD_CYC, 1_000_000, re-check interval; used only with SYSID_CHECK_PERIODIC_EN.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low.
- start  in  1  one-cycle request to run a check; ignored while busy.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when a check completes or aborts.
- id_ok  out  1  last ID read equalled EXP_ID.
- ts_ok  out  1  last timestamp read equalled EXP_TS.
- timeout_err  out  1  last check aborted on timeout.
- id_value  out  32  last captured ID word.
- ts_value  out  32  last captured timestamp word.
- avm_address  out  1  slave word select.
- avm_read  out  1  read strobe.
- avm_readdata  in  32  slave read data.
- avm_waitrequest  in  1  slave stall.

Behaviour:
- Reset (reset_n low at a clk edge) values: state IDLE; busy, done, id_ok, ts_ok, timeout_err, avm_read, avm_address = 0; id_value and ts_value = 0; timer cleared.
- Reset mid-read drops avm_read on the next edge. No done pulse is produced.
- FSM states: IDLE, RD_ID, RD_TS, FIN.
- IDLE:
  - start=1 moves to RD_ID on the next edge.
  - Clears timeout_err. Keeps id_ok and ts_ok until their new values are written.
- RD_ID: avm_read=1, avm_address=0.
  - Read completes in a cycle with avm_read=1 and avm_waitrequest=0. readdata is captured in that cycle (zero-latency slave).
  - On completion: id_value<=readdata, id_ok<=(readdata==EXP_ID), go to RD_TS.
- RD_TS: avm_read=1, avm_address=1. Same capture rule, writing ts_value and ts_ok; then go to FIN.
- FIN: done=1 for exactly one cycle, busy=0 next cycle, return to IDLE.
- Outputs are registered (Moore). avm_read and avm_address change only on state transitions.
- Minimum latency with no waitrequest: start at cycle 0; RD_ID at cycle 1; RD_TS at cycle 2; done at cycle 3.
- Back-to-back reads: avm_read stays high across RD_ID→RD_TS and only the address changes.
- Timeout:
  - The timer clears on entry to each read state and increments each cycle waitrequest=1.
  - If waitrequest is still 1 when the timer reaches TIMEOUT_CYC-1: drop avm_read, set timeout_err=1, id_ok=0, ts_ok=0, go to FIN.
  - Values captured before the abort are retained.
- Completion wins a tie: if waitrequest falls in the same cycle the timer hits the limit, the read completes and no timeout is flagged.
- start asserted during busy or FIN is dropped and is not queued.
- start asserted in the same cycle that done is pulsed is ignored.

Optional Feature:
- Macro: SYSID_CHECK_PERIODIC_EN.
- Defined:
  - A free-running counter (width clog2(PERIOD_CYC)) auto-triggers a check from IDLE every PERIOD_CYC cycles.
  - If the trigger fires while busy, it is held pending and issued on return to IDLE.
  - An extra sticky output mismatch_sticky (1 bit) sets on any check ending with id_ok=0, ts_ok=0 or timeout_err=1, and clears only on reset.
- Undefined: checks run only on start. No counter, no pending flag, and no mismatch_sticky port.

Decomposition:
- Package sysid_check_pkg: FSM state enum; ADDR_ID=1'b0, ADDR_TS=1'b1; default TIMEOUT_CYC; timer width function.
- One sub-module, sysid_check_timer: load/clear, enable, terminal-count flag. It is instantiated once for the timeout and once more for the periodic trigger under the macro.

Test Plan:
- EXP_ID=32'h1234_5678, EXP_TS=32'h0A0B_0C0D, model returns matching words with waitrequest=0; pulse start -> reads at addr 0 then 1 on consecutive cycles, done at cycle 3, id_ok=1, ts_ok=1, timeout_err=0.
- Model returns 32'h1234_5679 for the ID -> id_ok=0, ts_ok=1, id_value=32'h1234_5679.
- waitrequest held 5 cycles on each read, TIMEOUT_CYC=256 -> done at cycle 13; avm_address held stable during each stall.
- waitrequest stuck high, TIMEOUT_CYC=8 -> avm_read drops after 8 cycles in RD_ID, timeout_err=1, id_ok=ts_ok=0, done pulsed once.
- reset_n low for one cycle during RD_TS stall -> all outputs at reset values the next cycle, no done pulse; a new start then passes normally.
- Macro defined, PERIOD_CYC=50, no start -> checks run at cycles 50 and 100; a forced mismatch on the second check sets mismatch_sticky, which stays set after a passing third check.
